thread_regfile: RTL and testbench

//  Per-thread 16 x DATA_BITS register file: the stage directly upstream and downstream of the thread ALU.

---
 rtl/thread_regfile_if.sv | 35 +++
 rtl/thread_regfile.sv | 78 +++++++
 tb/tb_thread_regfile.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/thread_regfile_if.sv
// Operand/writeback bus between a thread lane's register file and the core that sequences it.
// The master drives control, decode fields and writeback sources; the slave returns rs/rt.
interface thread_regfile_if #(
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic [7:0]           block_id;
  logic [2:0]           core_state;
  logic [3:0]           decoded_rd_address;
  logic [3:0]           decoded_rs_address;
  logic [3:0]           decoded_rt_address;
  logic                 decoded_reg_write_enable;
  logic [1:0]           decoded_reg_input_mux;
  logic [DATA_BITS-1:0] decoded_immediate;
  logic [DATA_BITS-1:0] alu_out;
  logic [DATA_BITS-1:0] lsu_out;
  logic [DATA_BITS-1:0] rs;
  logic [DATA_BITS-1:0] rt;

  modport master (
    output enable, block_id, core_state,
    output decoded_rd_address, decoded_rs_address, decoded_rt_address,
    output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
    output alu_out, lsu_out,
    input  rs, rt
  );

  modport slave (
    input  enable, block_id, core_state,
    input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
    input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
    input  alu_out, lsu_out,
    output rs, rt
  );
endinterface

// File: rtl/thread_regfile.sv
// Per-thread 16-entry register file: R0-R12 general purpose, R13 = blockIdx,
// R14 = blockDim, R15 = threadIdx. Operands are registered in REQUEST, writeback happens in UPDATE.
module thread_regfile #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input logic              clk,
  input logic              reset,
  thread_regfile_if.slave  bus
);
  localparam logic [2:0] STATE_REQUEST = 3'b011;
  localparam logic [2:0] STATE_UPDATE  = 3'b110;

  logic [DATA_BITS-1:0] regs [16];
  logic [DATA_BITS-1:0] wr_data_next;
  logic [DATA_BITS-1:0] block_id_ext;
  logic [DATA_BITS-1:0] rs_reg;
  logic [DATA_BITS-1:0] rt_reg;
  logic                 read_en;
  logic                 write_en;

  assign block_id_ext = DATA_BITS'(bus.block_id);
  assign read_en      = bus.enable && (bus.core_state == STATE_REQUEST);
  // Mux code 11 means "no writeback", so it gates the write strobe rather than selecting data.
  assign write_en     = bus.enable && (bus.core_state == STATE_UPDATE) &&
                        bus.decoded_reg_write_enable && (bus.decoded_reg_input_mux != 2'b11);

  always_comb begin
    wr_data_next = bus.alu_out;
    case (bus.decoded_reg_input_mux)
      2'b01:   wr_data_next = bus.lsu_out;
      2'b10:   wr_data_next = bus.decoded_immediate;
      default: wr_data_next = bus.alu_out;
    endcase
  end

  // Only R0-R12 have write logic, so writes addressed to R13-R15 fall away naturally.
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_gpr
      logic [DATA_BITS-1:0] gpr_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          gpr_reg <= '0;
        end else if (write_en && (bus.decoded_rd_address == 4'(gi))) begin
          gpr_reg <= wr_data_next;
        end
      end
      assign regs[gi] = gpr_reg;
    end
  endgenerate

  logic [DATA_BITS-1:0] block_idx_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_idx_reg <= '0;
    end else if (bus.enable) begin
      block_idx_reg <= block_id_ext;
    end
  end

  assign regs[13] = block_idx_reg;
  assign regs[14] = DATA_BITS'(THREADS_PER_BLOCK);
  assign regs[15] = DATA_BITS'(THREAD_ID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_reg <= '0;
      rt_reg <= '0;
    end else if (read_en) begin
      rs_reg <= regs[bus.decoded_rs_address];
      rt_reg <= regs[bus.decoded_rt_address];
    end
  end

  assign bus.rs = rs_reg;
  assign bus.rt = rt_reg;
endmodule

// File: tb/tb_thread_regfile.sv
// Directed bench for thread_regfile: expected operands are queued as each cycle is driven
// and popped/checked one clock later.
module tb_thread_regfile;
  localparam int DATA_BITS = 8;
  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  typedef struct {
    string          tag;
    logic [7:0]     rs;
    logic [7:0]     rt;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [7:0] last_rs;
  logic [7:0] last_rt;
  exp_t sb_q[$];

  thread_regfile_if #(.DATA_BITS(DATA_BITS)) bus ();

  thread_regfile #(
    .THREADS_PER_BLOCK (4),
    .THREAD_ID         (2),
    .DATA_BITS         (DATA_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check();
    exp_t e;
    n_checks++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("txn %-14s state=%03b rs=%02h rt=%02h (exp %02h %02h)",
               e.tag, bus.core_state, bus.rs, bus.rt, e.rs, e.rt);
      check_val({e.tag, ".rs"}, bus.rs, e.rs);
      check_val({e.tag, ".rt"}, bus.rt, e.rt);
    end
  endtask

  // One clock: drive state/addresses at negedge, queue expectation, check #1 after posedge.
  task automatic cycle(input string tag, input logic [2:0] st, input logic [3:0] rs_a,
                       input logic [3:0] rt_a, input logic [7:0] exp_rs, input logic [7:0] exp_rt);
    exp_t e;
    @(negedge clk);
    bus.core_state         = st;
    bus.decoded_rs_address = rs_a;
    bus.decoded_rt_address = rt_a;
    e.tag = tag;
    e.rs  = exp_rs;
    e.rt  = exp_rt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check();
    last_rs = exp_rs;
    last_rt = exp_rt;
  endtask

  task automatic request(input string tag, input logic [3:0] rs_a, input logic [3:0] rt_a,
                         input logic [7:0] exp_rs, input logic [7:0] exp_rt);
    cycle(tag, ST_REQUEST, rs_a, rt_a, exp_rs, exp_rt);
  endtask

  // UPDATE never touches rs/rt, so the expectation is "hold".
  task automatic update(input string tag, input logic [3:0] rd, input logic [1:0] mux,
                        input logic we, input logic [7:0] imm, input logic [7:0] alu,
                        input logic [7:0] lsu);
    bus.decoded_rd_address       = rd;
    bus.decoded_reg_input_mux    = mux;
    bus.decoded_reg_write_enable = we;
    bus.decoded_immediate        = imm;
    bus.alu_out                  = alu;
    bus.lsu_out                  = lsu;
    cycle(tag, ST_UPDATE, 4'h0, 4'h0, last_rs, last_rt);
    bus.decoded_reg_write_enable = 1'b0;
  endtask

  initial begin
    logic [7:0] model [16];
    logic [3:0] a_rs;
    logic [3:0] a_rt;
    logic [7:0] e_rs;
    logic [7:0] e_rt;

    n_checks = 0;
    n_fail   = 0;
    last_rs  = 8'h00;
    last_rt  = 8'h00;
    bus.enable                   = 1'b1;
    bus.block_id                 = 8'h00;
    bus.core_state               = ST_IDLE;
    bus.decoded_rd_address       = 4'h0;
    bus.decoded_rs_address       = 4'h0;
    bus.decoded_rt_address       = 4'h0;
    bus.decoded_reg_write_enable = 1'b0;
    bus.decoded_reg_input_mux    = 2'b00;
    bus.decoded_immediate        = 8'h00;
    bus.alu_out                  = 8'h00;
    bus.lsu_out                  = 8'h00;

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset.rs", bus.rs, 8'h00);
    check_val("reset.rt", bus.rt, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Identity registers and cleared GPRs
    request("id_r14_r15", 4'd14, 4'd15, 8'h04, 8'h02);
    for (int i = 0; i < 13; i += 2) begin
      a_rs = 4'(i);
      a_rt = 4'(12 - i);
      request("gpr_zero", a_rs, a_rt, 8'h00, 8'h00);
    end
    request("r13_zero", 4'd13, 4'd0, 8'h00, 8'h00);

    // Writeback sources
    update("wb_imm", 4'd3, 2'b10, 1'b1, 8'h5A, 8'hEE, 8'hDD);
    request("rd_imm", 4'd3, 4'd0, 8'h5A, 8'h00);
    update("wb_alu", 4'd3, 2'b00, 1'b1, 8'hC3, 8'hFF, 8'hDD);
    request("rd_alu", 4'd0, 4'd3, 8'h00, 8'hFF);
    update("wb_lsu", 4'd3, 2'b01, 1'b1, 8'hC3, 8'hFF, 8'h11);
    request("rd_lsu", 4'd3, 4'd3, 8'h11, 8'h11);
    update("wb_r0", 4'd0, 2'b10, 1'b1, 8'hA5, 8'h00, 8'h00);
    request("rd_r0", 4'd0, 4'd12, 8'hA5, 8'h00);

    // Dropped writes
    update("wb_r15", 4'd15, 2'b10, 1'b1, 8'h77, 8'h77, 8'h77);
    update("wb_r14", 4'd14, 2'b00, 1'b1, 8'h77, 8'h77, 8'h77);
    request("ro_r15_r14", 4'd15, 4'd14, 8'h02, 8'h04);
    update("wb_we0", 4'd5, 2'b10, 1'b0, 8'h44, 8'h44, 8'h44);
    update("wb_mux11", 4'd5, 2'b11, 1'b1, 8'h44, 8'h44, 8'h44);
    request("r5_unchg", 4'd5, 4'd3, 8'h00, 8'h11);

    // R13 tracking and enable gating
    bus.block_id = 8'h09;
    request("r13_preedge", 4'd13, 4'd13, 8'h00, 8'h00);
    request("r13_09", 4'd13, 4'd3, 8'h09, 8'h11);
    bus.enable   = 1'b0;
    bus.block_id = 8'h0A;
    request("dis_hold", 4'd14, 4'd15, 8'h09, 8'h11);
    update("dis_nowr", 4'd3, 2'b10, 1'b1, 8'hBB, 8'hBB, 8'hBB);
    bus.enable = 1'b1;
    request("reen_r13", 4'd13, 4'd3, 8'h09, 8'h11);
    request("r13_0a", 4'd13, 4'd14, 8'h0A, 8'h04);

    // Every core_state value: only 011 updates the operands
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model[0]  = 8'hA5;
    model[3]  = 8'h11;
    model[13] = 8'h0A;
    model[14] = 8'h04;
    model[15] = 8'h02;
    e_rs = last_rs;
    e_rt = last_rt;
    for (int s = 0; s < 8; s++) begin
      a_rs = (s % 2 == 0) ? 4'd3 : 4'd15;
      a_rt = (s % 2 == 0) ? 4'd14 : 4'd0;
      if (3'(s) == ST_REQUEST) begin
        e_rs = model[a_rs];
        e_rt = model[a_rt];
      end
      cycle("state_sweep", 3'(s), a_rs, a_rt, e_rs, e_rt);
    end

    // Asynchronous reset in the middle of an UPDATE
    update("wb_r7", 4'd7, 2'b10, 1'b1, 8'h33, 8'h00, 8'h00);
    request("rd_r7", 4'd7, 4'd15, 8'h33, 8'h02);
    @(negedge clk);
    bus.core_state               = ST_UPDATE;
    bus.decoded_rd_address       = 4'd7;
    bus.decoded_reg_input_mux    = 2'b10;
    bus.decoded_reg_write_enable = 1'b1;
    bus.decoded_immediate        = 8'h55;
    #2;
    reset = 1'b0;
    #1;
    check_val("async_rst.rs", bus.rs, 8'h00);
    check_val("async_rst.rt", bus.rt, 8'h00);
    @(negedge clk);
    reset                        = 1'b1;
    bus.core_state               = ST_IDLE;
    bus.decoded_reg_write_enable = 1'b0;
    last_rs = 8'h00;
    last_rt = 8'h00;
    request("post_rst_r7", 4'd7, 4'd14, 8'h00, 8'h04);
    request("post_rst_r3", 4'd3, 4'd0, 8'h00, 8'h00);

    n_checks++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
